// File: rtl/vid_in_timing_meas_if.sv
// Video input timing measurement bundle: raw DE/syncs towards the meter and
// the measured timing, polarity and status flags back out.
interface vid_in_timing_meas_if #(
   parameter int W = 12
);
   logic         de_in;
   logic         hsync_in;
   logic         vsync_in;
   logic [W-1:0] h_total;
   logic [W-1:0] h_active;
   logic [W-1:0] h_sync;
   logic [W-1:0] v_total;
   logic [W-1:0] v_active;
   logic         hsync_pol;
   logic         vsync_pol;
   logic         locked;
   logic         no_signal;
   logic         frame_strobe;

   modport master (
      output de_in, hsync_in, vsync_in,
      input  h_total, h_active, h_sync, v_total, v_active,
      input  hsync_pol, vsync_pol, locked, no_signal, frame_strobe
   );

   modport slave (
      input  de_in, hsync_in, vsync_in,
      output h_total, h_active, h_sync, v_total, v_active,
      output hsync_pol, vsync_pol, locked, no_signal, frame_strobe
   );
endinterface

// File: rtl/vid_in_timing_meas.sv
// Measures incoming video timing (totals, active sizes, hsync width, sync
// polarities) and flags lock once consecutive frames measure identically.
module vid_in_timing_meas #(
   parameter int W           = 12,
   parameter int TIMEOUT     = 1048575,
   parameter int LOCK_FRAMES = 2
) (
   input  logic                vid_clk,
   input  logic                vid_reset,
   vid_in_timing_meas_if.slave vid
);
   localparam int TW       = $clog2(TIMEOUT + 1);
   localparam int MW       = (LOCK_FRAMES < 2) ? 1 : $clog2(LOCK_FRAMES + 1);
   localparam int LOCK_MIN = LOCK_FRAMES - 1;

   localparam logic [W-1:0]  CNT_MAX   = '1;
   localparam logic [MW-1:0] MATCH_MAX = '1;
   localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);
   localparam logic [TW-1:0] TO_MAX    = TW'(TIMEOUT);

   typedef enum logic [1:0] {NO_SIGNAL, ACQUIRE, MEASURE, LOCKED} state_t;

   function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
      return (v == CNT_MAX) ? v : v + W'(1);
   endfunction

   function automatic logic [MW-1:0] sat_inc_m(input logic [MW-1:0] v);
      return (v == MATCH_MAX) ? v : v + MW'(1);
   endfunction

   logic de_r, hs_r, vs_r;
   logic de_d, hs_n_d, vs_n_d;
   logic hsync_pol, vsync_pol;
   logic hs_n, vs_n;
   logic line_start, frame_start, de_rise, de_fall, pol_chg, timeout;

   logic [W-1:0]  pix_cnt, h_total_w, h_sync_w, de_cnt, h_active_w;
   logic [W-1:0]  line_cnt, v_active_w;
   logic          de_seen;
   logic [TW-1:0] to_cnt;

   state_t        state;
   logic [MW-1:0] match_cnt;
   logic          locked, no_signal, frame_strobe;
   logic [W-1:0]  h_total, h_active, h_sync, v_total, v_active;

   logic [W-1:0]  h_total_nx, h_active_nx, v_total_nx, v_active_nx;
   logic [MW-1:0] match_nx;
   logic          same, any_sat, frame_ok, lock_ok;

   assign hs_n        = hs_r ~^ hsync_pol;
   assign vs_n        = vs_r ~^ vsync_pol;
   assign line_start  = hs_n & ~hs_n_d;
   assign frame_start = vs_n & ~vs_n_d;
   assign de_rise     = de_r & ~de_d;
   assign de_fall     = ~de_r & de_d;
   assign pol_chg     = de_rise & ((~hs_r != hsync_pol) | (~vs_r != vsync_pol));
   assign timeout     = ~line_start & (to_cnt == TO_LAST);

   // Frame-end view: a line start in the same cycle is folded in first.
   assign h_total_nx  = line_start ? pix_cnt : h_total_w;
   assign h_active_nx = de_fall ? de_cnt : h_active_w;
   assign v_total_nx  = line_start ? sat_inc(line_cnt) : line_cnt;
   assign v_active_nx = (line_start && de_seen) ? sat_inc(v_active_w) : v_active_w;

   assign same     = (h_total_nx == h_total) && (h_active_nx == h_active) &&
                     (v_total_nx == v_total) && (v_active_nx == v_active);
   assign any_sat  = (h_total_nx == CNT_MAX) || (h_active_nx == CNT_MAX) ||
                     (h_sync_w == CNT_MAX) || (v_total_nx == CNT_MAX) ||
                     (v_active_nx == CNT_MAX);
   assign frame_ok = same && !any_sat;
   assign match_nx = frame_ok ? sat_inc_m(match_cnt) : '0;
   assign lock_ok  = frame_ok && (int'(match_nx) >= LOCK_MIN);

   // Input capture, polarity learning and per-line / per-frame working counters
   always_ff @(posedge vid_clk or posedge vid_reset) begin
      if (vid_reset) begin
         de_r       <= 1'b0;
         hs_r       <= 1'b0;
         vs_r       <= 1'b0;
         de_d       <= 1'b0;
         hs_n_d     <= 1'b0;
         vs_n_d     <= 1'b0;
         hsync_pol  <= 1'b1;
         vsync_pol  <= 1'b1;
         pix_cnt    <= '0;
         h_total_w  <= '0;
         h_sync_w   <= '0;
         de_cnt     <= '0;
         h_active_w <= '0;
         de_seen    <= 1'b0;
         line_cnt   <= '0;
         v_active_w <= '0;
         to_cnt     <= '0;
      end else begin
         de_r   <= vid.de_in;
         hs_r   <= vid.hsync_in;
         vs_r   <= vid.vsync_in;
         de_d   <= de_r;
         hs_n_d <= hs_n;
         vs_n_d <= vs_n;

         // Syncs are inactive during active video, so DE rising reveals polarity.
         if (de_rise) begin
            hsync_pol <= ~hs_r;
            vsync_pol <= ~vs_r;
         end

         if (line_start) begin
            pix_cnt   <= W'(1);
            h_total_w <= pix_cnt;
            h_sync_w  <= W'(1);
            de_seen   <= de_r;
            to_cnt    <= '0;
         end else begin
            pix_cnt <= sat_inc(pix_cnt);
            if (hs_n)
               h_sync_w <= sat_inc(h_sync_w);
            de_seen <= de_seen | de_r;
            if (to_cnt != TO_MAX)
               to_cnt <= to_cnt + TW'(1);
         end

         if (de_rise)
            de_cnt <= W'(1);
         else if (de_r)
            de_cnt <= sat_inc(de_cnt);
         if (de_fall)
            h_active_w <= de_cnt;

         if (frame_start) begin
            line_cnt   <= '0;
            v_active_w <= '0;
         end else begin
            line_cnt   <= v_total_nx;
            v_active_w <= v_active_nx;
         end
      end
   end

   // Lock state machine and registered measurement outputs
   always_ff @(posedge vid_clk or posedge vid_reset) begin
      if (vid_reset) begin
         state        <= NO_SIGNAL;
         match_cnt    <= '0;
         locked       <= 1'b0;
         no_signal    <= 1'b1;
         frame_strobe <= 1'b0;
         h_total      <= '0;
         h_active     <= '0;
         h_sync       <= '0;
         v_total      <= '0;
         v_active     <= '0;
      end else begin
         frame_strobe <= 1'b0;
         case (state)
            NO_SIGNAL: begin
               if (line_start) begin
                  state     <= ACQUIRE;
                  no_signal <= 1'b0;
               end
            end
            ACQUIRE: begin
               if (frame_start)
                  state <= MEASURE;
            end
            default: begin
               if (frame_start) begin
                  h_total      <= h_total_nx;
                  h_active     <= h_active_nx;
                  h_sync       <= h_sync_w;
                  v_total      <= v_total_nx;
                  v_active     <= v_active_nx;
                  frame_strobe <= 1'b1;
                  match_cnt    <= match_nx;
                  locked       <= lock_ok;
                  state        <= lock_ok ? LOCKED : MEASURE;
               end
            end
         endcase

         if (pol_chg) begin
            match_cnt <= '0;
            locked    <= 1'b0;
            if (state == LOCKED)
               state <= MEASURE;
         end

         // Loss of hsync wins over everything; last measurements are kept.
         if (timeout && state != NO_SIGNAL) begin
            state     <= NO_SIGNAL;
            no_signal <= 1'b1;
            locked    <= 1'b0;
            match_cnt <= '0;
         end
      end
   end

   assign vid.h_total      = h_total;
   assign vid.h_active     = h_active;
   assign vid.h_sync       = h_sync;
   assign vid.v_total      = v_total;
   assign vid.v_active     = v_active;
   assign vid.hsync_pol    = hsync_pol;
   assign vid.vsync_pol    = vsync_pol;
   assign vid.locked       = locked;
   assign vid.no_signal    = no_signal;
   assign vid.frame_strobe = frame_strobe;
endmodule
